ps2_mouse_device_sm: RTL and testbench
======================================

# ps2_mouse_device_sm

Byte-level PS/2 mouse device state machine: the device end of the host command protocol. It sits between a device-side PS/2 receiver/transmitter pair and a movement source. It answers host commands (reset, enable/disable streaming, set sample rate, get device ID), tracks the IntelliMouse unlock sequence, and streams 3- or 4-byte movement packets. It is used as a bus-functional mouse model and as an FPGA mouse emulator.

## Interface
Parameters:
- BAT_DELAY, 25_000_000: cycles between reset/FF-ack and the AA byte (0.5 s at 50 MHz; benches override to a small value).

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- READ_ENABLE  out  1  receiver enable; high whenever no byte is in transmission.
- BYTE_READY  in  1  one-cycle pulse: host byte received.
- BYTE_READ  in  8  received byte; valid with BYTE_READY.
- BYTE_ERROR_CODE  in  2  00 means good; anything else is a framing/parity error.
- SEND_BYTE  out  1  one-cycle pulse: start transmitting BYTE_TO_SEND.
- BYTE_TO_SEND  out  8  byte to transmit; held until BYTE_SENT.
- BYTE_SENT  in  1  one-cycle pulse: transmission complete.
- MOVE_VALID  in  1  movement sample offered.
- MOVE_ACCEPT  out  1  one-cycle pulse: sample latched.
- MOVE_BUTTONS  in  3  {middle, right, left}.
- MOVE_DX, MOVE_DY  in  9 each  two's complement deltas.
- MOVE_DZ  in  4  two's complement wheel delta.
- STREAMING  out  1  data reporting enabled.
- INTELLIMOUSE  out  1  4-byte packet mode active.
- SAMPLE_RATE  out  8  last accepted rate value.

## Operation
- States: BAT_WAIT, SEND_AA, SEND_ID, IDLE, ACK, RESP, RATE_ARG, PKT0–PKT3.
- Send handshake: a send state pulses SEND_BYTE once, then waits for BYTE_SENT before it advances.
- Power-up and FF behave the same after the ack: BAT_WAIT counts BAT_DELAY cycles → AA → 00 → IDLE. Both clear STREAMING, INTELLIMOUSE and the rate history, and set SAMPLE_RATE=0x64.
- IDLE dispatch when BYTE_READY arrives:
  - error code ≠ 00: send FE.
  - FF: send FA, then the BAT sequence.
  - F4: send FA, set STREAMING.
  - F5: send FA, clear STREAMING.
  - F3: send FA, then go to RATE_ARG.
  - F2: send FA, then the ID byte (03 if INTELLIMOUSE, else 00).
  - any other byte: send FE.
- RATE_ARG: the next good byte is latched into SAMPLE_RATE and acked with FA. An error byte gets FE and returns to IDLE.
- Rate history: a 3-deep history of accepted rates. Each acceptance shifts it. History = 200,100,80 (oldest first) sets INTELLIMOUSE; only FF or RESET clears it.
- Packet start: in IDLE, with STREAMING=1, MOVE_VALID=1 and no BYTE_READY, latch the sample and pulse MOVE_ACCEPT.
- Packet bytes:
  - byte0 = {0, 0, DY[8], DX[8], 1, BUTTONS}.
  - byte1 = DX[7:0].
  - byte2 = DY[7:0].
  - byte3 (INTELLIMOUSE only) = sign-extended DZ.
  - After the last byte, return to IDLE.
- Host byte during a packet: the current byte finishes, the rest of the packet is dropped, and the command is dispatched. BYTE_READY is captured into a 1-entry pending register while transmitting.
- Reset mid-operation returns the block to BAT_WAIT with all state cleared.

## Timing
- Reset values: READ_ENABLE=0, SEND_BYTE=0, BYTE_TO_SEND=00, MOVE_ACCEPT=0, STREAMING=0, INTELLIMOUSE=0, SAMPLE_RATE=0x64.
- BYTE_READY sampled in cycle N → SEND_BYTE in cycle N+1.
- BYTE_SENT in cycle M → next byte's SEND_BYTE in cycle M+1, or IDLE in M+1.
- READ_ENABLE is low from the SEND_BYTE cycle through the BYTE_SENT cycle, and high otherwise (except during reset).
- AA is sent exactly BAT_DELAY+1 cycles after reset is released, or after BYTE_SENT of the FF ack.
- BYTE_READY and MOVE_VALID in the same cycle: the command wins and MOVE_ACCEPT is not asserted.
- MOVE_ACCEPT goes high the cycle before byte0's SEND_BYTE.

## Structure
- A shared package holds:
  - command constants: CMD_RESET=FF, CMD_ENABLE=F4, CMD_DISABLE=F5, CMD_SET_RATE=F3, CMD_GET_ID=F2.
  - response constants: ACK=FA, RESEND=FE, BAT_OK=AA, ID_STD=00, ID_WHEEL=03.
  - the state encoding.
- One sub-module, ps2_packet_builder: combinational build of the 4 packet bytes from the latched sample.

## Test plan
- Power-up with BAT_DELAY=10 → AA then 00 → IDLE; STREAMING=0.
- FF → FA, then after BAT_DELAY: AA, 00; SAMPLE_RATE=0x64.
- F3,C8,F3,64,F3,50,F2 → seven FA, then 03; INTELLIMOUSE=1. The same sequence with 3C in place of 50 → ID 00.
- F4, then move btn=001, dx=+5, dy=−3 → FA, then bytes 29,05,FD; MOVE_ACCEPT one pulse.
- With INTELLIMOUSE=1 and streaming, move dz=−1, dx=0, dy=0, btn=000 → 08,00,00,FF.
- Error code 01 on F4 → FE, STREAMING stays 0. F5 arriving mid-packet → current byte completes, then FA, and no further packet bytes.

Source files
------------

// File: rtl/ps2_mouse_device_sm_pkg.sv
// Shared constants and state encoding for the PS/2 mouse device model.
// Command bytes from the host, response bytes to the host, and the control FSM states.
package ps2_mouse_device_sm_pkg;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_DISABLE  = 8'hF5;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] CMD_GET_ID   = 8'hF2;

  localparam logic [7:0] ACK      = 8'hFA;
  localparam logic [7:0] RESEND   = 8'hFE;
  localparam logic [7:0] BAT_OK   = 8'hAA;
  localparam logic [7:0] ID_STD   = 8'h00;
  localparam logic [7:0] ID_WHEEL = 8'h03;

  localparam logic [7:0] RATE_DEFAULT = 8'h64;

  typedef enum logic [3:0] {
    ST_BAT_WAIT,
    ST_SEND_AA,
    ST_SEND_ID,
    ST_IDLE,
    ST_ACK,
    ST_RESP,
    ST_RATE_ARG,
    ST_PKT0,
    ST_PKT1,
    ST_PKT2,
    ST_PKT3
  } state_t;

  typedef struct packed {
    logic [2:0] buttons;
    logic [8:0] dx;
    logic [8:0] dy;
    logic [3:0] dz;
  } move_t;

  // States that own the transmitter: SEND_BYTE pulse through BYTE_SENT.
  function automatic logic is_send(input state_t s);
    return s inside {ST_SEND_AA, ST_SEND_ID, ST_ACK, ST_RESP,
                     ST_PKT0, ST_PKT1, ST_PKT2, ST_PKT3};
  endfunction

endpackage

// File: rtl/ps2_mouse_device_sm_packet_builder.sv
// Forms the four movement-packet bytes from a latched movement sample.
module ps2_packet_builder
  import ps2_mouse_device_sm_pkg::*;
(
  input  move_t            sample,
  output logic [3:0][7:0]  pkt_bytes
);

  always_comb begin
    pkt_bytes[0] = {2'b00, sample.dy[8], sample.dx[8], 1'b1, sample.buttons};
    pkt_bytes[1] = sample.dx[7:0];
    pkt_bytes[2] = sample.dy[7:0];
    pkt_bytes[3] = {{4{sample.dz[3]}}, sample.dz};
  end

endmodule

// File: rtl/ps2_mouse_device_sm.sv
// Device end of the PS/2 mouse host protocol: command responses, BAT sequence,
// IntelliMouse unlock tracking and 3/4-byte movement packet streaming.
module ps2_mouse_device_sm
  import ps2_mouse_device_sm_pkg::*;
#(
  parameter int BAT_DELAY = 25_000_000
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       READ_ENABLE,
  input  logic       BYTE_READY,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  input  logic       MOVE_VALID,
  output logic       MOVE_ACCEPT,
  input  logic [2:0] MOVE_BUTTONS,
  input  logic [8:0] MOVE_DX,
  input  logic [8:0] MOVE_DY,
  input  logic [3:0] MOVE_DZ,
  output logic       STREAMING,
  output logic       INTELLIMOUSE,
  output logic [7:0] SAMPLE_RATE
);

  state_t          state_q, state_d;
  state_t          after_q, after_d;
  logic            sent_q, sent_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [7:0]      resp_q, resp_d;
  logic            pend_q, pend_d;
  logic [7:0]      pend_byte_q, pend_byte_d;
  logic [1:0]      pend_err_q, pend_err_d;
  logic            stream_q, stream_d;
  logic            intelli_q, intelli_d;
  logic [7:0]      rate_q, rate_d;
  logic [2:0][7:0] hist_q, hist_d;
  move_t           move_q, move_d;

  logic            send_st, tx_done, abort, cmd_vld, cmd_ok;
  logic [7:0]      cmd_byte;
  logic [3:0][7:0] pkt_bytes;

  ps2_packet_builder u_pkt (
    .sample    (move_q),
    .pkt_bytes (pkt_bytes)
  );

  // A byte held in the pending register is served before a fresh one.
  assign send_st  = is_send(state_q);
  assign cmd_vld  = BYTE_READY | pend_q;
  assign cmd_byte = pend_q ? pend_byte_q : BYTE_READ;
  assign cmd_ok   = ((pend_q ? pend_err_q : BYTE_ERROR_CODE) == 2'b00);
  assign abort    = pend_q | BYTE_READY;

  assign READ_ENABLE  = !RESET && !send_st;
  assign STREAMING    = stream_q;
  assign INTELLIMOUSE = intelli_q;
  assign SAMPLE_RATE  = rate_q;

  always_comb begin
    BYTE_TO_SEND = 8'h00;
    case (state_q)
      ST_SEND_AA: BYTE_TO_SEND = BAT_OK;
      ST_SEND_ID: BYTE_TO_SEND = ID_STD;
      ST_ACK:     BYTE_TO_SEND = ACK;
      ST_RESP:    BYTE_TO_SEND = resp_q;
      ST_PKT0:    BYTE_TO_SEND = pkt_bytes[0];
      ST_PKT1:    BYTE_TO_SEND = pkt_bytes[1];
      ST_PKT2:    BYTE_TO_SEND = pkt_bytes[2];
      ST_PKT3:    BYTE_TO_SEND = pkt_bytes[3];
      default:    BYTE_TO_SEND = 8'h00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    after_d     = after_q;
    sent_d      = sent_q;
    cnt_d       = cnt_q;
    resp_d      = resp_q;
    pend_d      = pend_q;
    pend_byte_d = pend_byte_q;
    pend_err_d  = pend_err_q;
    stream_d    = stream_q;
    intelli_d   = intelli_q;
    rate_d      = rate_q;
    hist_d      = hist_q;
    move_d      = move_q;
    SEND_BYTE   = 1'b0;
    MOVE_ACCEPT = 1'b0;
    tx_done     = 1'b0;

    if (send_st) begin
      SEND_BYTE = !sent_q;
      sent_d    = 1'b1;
      if (BYTE_READY && !pend_q) begin
        pend_d      = 1'b1;
        pend_byte_d = BYTE_READ;
        pend_err_d  = BYTE_ERROR_CODE;
      end
      if (sent_q && BYTE_SENT) begin
        tx_done = 1'b1;
        sent_d  = 1'b0;
      end
    end

    case (state_q)
      ST_BAT_WAIT: begin
        if (cnt_q == 32'(BAT_DELAY - 1)) begin
          cnt_d   = '0;
          state_d = ST_SEND_AA;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_SEND_AA: if (tx_done) state_d = ST_SEND_ID;
      ST_SEND_ID: if (tx_done) state_d = ST_IDLE;
      ST_ACK:     if (tx_done) state_d = after_q;
      ST_RESP:    if (tx_done) state_d = ST_IDLE;
      ST_IDLE: begin
        if (cmd_vld) begin
          pend_d  = 1'b0;
          state_d = ST_ACK;
          after_d = ST_IDLE;
          if (!cmd_ok) begin
            state_d = ST_RESP;
            resp_d  = RESEND;
          end else begin
            case (cmd_byte)
              CMD_RESET: begin
                after_d   = ST_BAT_WAIT;
                stream_d  = 1'b0;
                intelli_d = 1'b0;
                rate_d    = RATE_DEFAULT;
                hist_d    = '0;
              end
              CMD_ENABLE:   stream_d = 1'b1;
              CMD_DISABLE:  stream_d = 1'b0;
              CMD_SET_RATE: after_d  = ST_RATE_ARG;
              CMD_GET_ID: begin
                after_d = ST_RESP;
                resp_d  = intelli_q ? ID_WHEEL : ID_STD;
              end
              default: begin
                state_d = ST_RESP;
                resp_d  = RESEND;
              end
            endcase
          end
        end else if (stream_q && MOVE_VALID) begin
          MOVE_ACCEPT = 1'b1;
          move_d      = '{buttons: MOVE_BUTTONS, dx: MOVE_DX, dy: MOVE_DY, dz: MOVE_DZ};
          state_d     = ST_PKT0;
        end
      end
      ST_RATE_ARG: begin
        if (cmd_vld) begin
          pend_d = 1'b0;
          if (!cmd_ok) begin
            state_d = ST_RESP;
            resp_d  = RESEND;
          end else begin
            // hist[0] is the newest rate; 200,100,80 in order unlocks the wheel.
            rate_d  = cmd_byte;
            hist_d  = {hist_q[1:0], cmd_byte};
            if (hist_q[1] == 8'd200 && hist_q[0] == 8'd100 && cmd_byte == 8'd80)
              intelli_d = 1'b1;
            state_d = ST_ACK;
            after_d = ST_IDLE;
          end
        end
      end
      ST_PKT0: if (tx_done) state_d = abort ? ST_IDLE : ST_PKT1;
      ST_PKT1: if (tx_done) state_d = abort ? ST_IDLE : ST_PKT2;
      ST_PKT2: if (tx_done) state_d = (abort || !intelli_q) ? ST_IDLE : ST_PKT3;
      ST_PKT3: if (tx_done) state_d = ST_IDLE;
      default: state_d = ST_BAT_WAIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_BAT_WAIT;
      after_q     <= ST_IDLE;
      sent_q      <= 1'b0;
      cnt_q       <= '0;
      resp_q      <= 8'h00;
      pend_q      <= 1'b0;
      pend_byte_q <= 8'h00;
      pend_err_q  <= 2'b00;
      stream_q    <= 1'b0;
      intelli_q   <= 1'b0;
      rate_q      <= RATE_DEFAULT;
      hist_q      <= '0;
      move_q      <= '0;
    end else begin
      state_q     <= state_d;
      after_q     <= after_d;
      sent_q      <= sent_d;
      cnt_q       <= cnt_d;
      resp_q      <= resp_d;
      pend_q      <= pend_d;
      pend_byte_q <= pend_byte_d;
      pend_err_q  <= pend_err_d;
      stream_q    <= stream_d;
      intelli_q   <= intelli_d;
      rate_q      <= rate_d;
      hist_q      <= hist_d;
      move_q      <= move_d;
    end
  end

endmodule

// File: tb/tb_ps2_mouse_device_sm.sv
// Directed bench: a host that sends command bytes and a transmitter that
// completes each byte three cycles after SEND_BYTE.
module tb_ps2_mouse_device_sm;

  localparam int BAT = 10;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       READ_ENABLE;
  logic       BYTE_READY = 1'b0;
  logic [7:0] BYTE_READ = 8'h00;
  logic [1:0] BYTE_ERROR_CODE = 2'b00;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT = 1'b0;
  logic       MOVE_VALID = 1'b0;
  logic       MOVE_ACCEPT;
  logic [2:0] MOVE_BUTTONS = 3'b000;
  logic [8:0] MOVE_DX = 9'h000;
  logic [8:0] MOVE_DY = 9'h000;
  logic [3:0] MOVE_DZ = 4'h0;
  logic       STREAMING;
  logic       INTELLIMOUSE;
  logic [7:0] SAMPLE_RATE;

  ps2_mouse_device_sm #(.BAT_DELAY(BAT)) dut (
    .CLK(CLK), .RESET(RESET), .READ_ENABLE(READ_ENABLE),
    .BYTE_READY(BYTE_READY), .BYTE_READ(BYTE_READ), .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
    .SEND_BYTE(SEND_BYTE), .BYTE_TO_SEND(BYTE_TO_SEND), .BYTE_SENT(BYTE_SENT),
    .MOVE_VALID(MOVE_VALID), .MOVE_ACCEPT(MOVE_ACCEPT), .MOVE_BUTTONS(MOVE_BUTTONS),
    .MOVE_DX(MOVE_DX), .MOVE_DY(MOVE_DY), .MOVE_DZ(MOVE_DZ),
    .STREAMING(STREAMING), .INTELLIMOUSE(INTELLIMOUSE), .SAMPLE_RATE(SAMPLE_RATE)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int rdy_cyc, rel_cyc, acc0;
  int acc_cnt = 0;
  int acc_cyc = 0;
  int extra_send = 0;
  int re_bad = 0;
  logic [7:0] tx_q[$];
  int send_cyc_q[$];
  int sent_cyc_q[$];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (MOVE_ACCEPT) begin
      acc_cnt <= acc_cnt + 1;
      acc_cyc <= cyc;
    end
  end

  // Transmitter: record each byte, then report completion after three cycles.
  initial begin
    int busy;
    busy = 0;
    forever begin
      @(negedge CLK);
      BYTE_SENT = 1'b0;
      if (RESET) begin
        busy = 0;
      end else if (busy > 0) begin
        if (SEND_BYTE) extra_send++;
        if (READ_ENABLE) re_bad++;
        busy--;
        if (busy == 0) begin
          BYTE_SENT = 1'b1;
          sent_cyc_q.push_back(cyc);
        end
      end else if (SEND_BYTE) begin
        if (READ_ENABLE) re_bad++;
        tx_q.push_back(BYTE_TO_SEND);
        send_cyc_q.push_back(cyc);
        busy = 3;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_tx(input int n);
    int i;
    i = 0;
    while (tx_q.size() < n && i < 300) begin
      @(posedge CLK);
      i++;
    end
    n_tests++;
    assert (tx_q.size() >= n) else begin
      n_fail++;
      $error("FAIL wait_tx: got %0d bytes, expected %0d", tx_q.size(), n);
    end
  endtask

  task automatic clr();
    tx_q.delete();
    send_cyc_q.delete();
    sent_cyc_q.delete();
  endtask

  task automatic settle();
    repeat (8) @(negedge CLK);
  endtask

  task automatic host_send(input logic [7:0] b, input logic [1:0] e);
    @(negedge CLK);
    BYTE_READY = 1'b1;
    BYTE_READ = b;
    BYTE_ERROR_CODE = e;
    rdy_cyc = cyc;
    @(negedge CLK);
    BYTE_READY = 1'b0;
    BYTE_ERROR_CODE = 2'b00;
  endtask

  task automatic do_move(input logic [2:0] btn, input logic [8:0] dx,
                         input logic [8:0] dy, input logic [3:0] dz);
    @(negedge CLK);
    MOVE_VALID = 1'b1;
    MOVE_BUTTONS = btn;
    MOVE_DX = dx;
    MOVE_DY = dy;
    MOVE_DZ = dz;
    @(posedge CLK);
    #1;
    MOVE_VALID = 1'b0;
  endtask

  task automatic rate_seq(input logic [7:0] third, input logic [7:0] exp_id);
    logic [7:0] seq [7];
    seq = '{8'hF3, 8'hC8, 8'hF3, 8'h64, 8'hF3, third, 8'hF2};
    clr();
    for (int i = 0; i < 7; i++) begin
      host_send(seq[i], 2'b00);
      wait_tx(i + 1);
      settle();
    end
    wait_tx(8);
    settle();
    for (int i = 0; i < 7; i++) chk("rate_seq_ack", tx_q[i], 8'hFA);
    chk("get_id", tx_q[7], exp_id);
    chk("rate_seq_len", tx_q.size(), 8);
    chk("rate_value", SAMPLE_RATE, third);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_read_enable", READ_ENABLE, 0);
    chk("rst_send_byte", SEND_BYTE, 0);
    chk("rst_byte_to_send", BYTE_TO_SEND, 8'h00);
    chk("rst_move_accept", MOVE_ACCEPT, 0);
    chk("rst_streaming", STREAMING, 0);
    chk("rst_intellimouse", INTELLIMOUSE, 0);
    chk("rst_sample_rate", SAMPLE_RATE, 8'h64);

    // Power-up BAT: AA lands BAT cycles after the first non-reset cycle begins
    RESET = 1'b0;
    rel_cyc = cyc;
    clr();
    wait_tx(2);
    settle();
    chk("por_aa", tx_q[0], 8'hAA);
    chk("por_id", tx_q[1], 8'h00);
    chk("por_aa_time", send_cyc_q[0] - rel_cyc, BAT);
    chk("por_streaming", STREAMING, 0);
    chk("idle_read_enable", READ_ENABLE, 1);

    // FF: ack, then the BAT sequence timed from the ack's BYTE_SENT
    clr();
    host_send(8'hFF, 2'b00);
    wait_tx(3);
    settle();
    chk("ff_ack", tx_q[0], 8'hFA);
    chk("ff_ack_latency", send_cyc_q[0] - rdy_cyc, 1);
    chk("ff_aa", tx_q[1], 8'hAA);
    chk("ff_id", tx_q[2], 8'h00);
    chk("ff_aa_time", send_cyc_q[1] - sent_cyc_q[0], BAT + 1);
    chk("ff_rate", SAMPLE_RATE, 8'h64);

    // Framing error on F4, then an unknown command
    clr();
    host_send(8'hF4, 2'b01);
    wait_tx(1);
    settle();
    chk("err_resend", tx_q[0], 8'hFE);
    chk("err_streaming", STREAMING, 0);
    clr();
    host_send(8'hE8, 2'b00);
    wait_tx(1);
    settle();
    chk("unknown_resend", tx_q[0], 8'hFE);

    // Standard 3-byte packet
    clr();
    host_send(8'hF4, 2'b00);
    wait_tx(1);
    settle();
    chk("f4_ack", tx_q[0], 8'hFA);
    chk("f4_streaming", STREAMING, 1);
    clr();
    acc0 = acc_cnt;
    do_move(3'b001, 9'd5, 9'h1FD, 4'h0);
    wait_tx(3);
    repeat (12) @(negedge CLK);
    chk("pkt_b0", tx_q[0], 8'h29);
    chk("pkt_b1", tx_q[1], 8'h05);
    chk("pkt_b2", tx_q[2], 8'hFD);
    chk("pkt_len", tx_q.size(), 3);
    chk("pkt_accepts", acc_cnt - acc0, 1);
    chk("accept_to_send", send_cyc_q[0] - acc_cyc, 1);

    // Rate history: 200,100,60 keeps the standard ID; 200,100,80 unlocks the wheel
    rate_seq(8'h3C, 8'h00);
    chk("no_unlock", INTELLIMOUSE, 0);
    rate_seq(8'h50, 8'h03);
    chk("unlock", INTELLIMOUSE, 1);

    // 4-byte wheel packet
    clr();
    do_move(3'b000, 9'd0, 9'd0, 4'hF);
    wait_tx(4);
    repeat (12) @(negedge CLK);
    chk("whl_b0", tx_q[0], 8'h08);
    chk("whl_b1", tx_q[1], 8'h00);
    chk("whl_b2", tx_q[2], 8'h00);
    chk("whl_b3", tx_q[3], 8'hFF);
    chk("whl_len", tx_q.size(), 4);

    // F5 during byte0: byte0 completes, then only the ack
    clr();
    do_move(3'b001, 9'd5, 9'h1FD, 4'h0);
    wait_tx(1);
    host_send(8'hF5, 2'b00);
    wait_tx(2);
    repeat (20) @(negedge CLK);
    chk("abort_b0", tx_q[0], 8'h29);
    chk("abort_ack", tx_q[1], 8'hFA);
    chk("abort_len", tx_q.size(), 2);
    chk("abort_streaming", STREAMING, 0);

    // Command and movement in the same cycle: command wins
    clr();
    host_send(8'hF4, 2'b00);
    wait_tx(1);
    settle();
    clr();
    acc0 = acc_cnt;
    @(negedge CLK);
    BYTE_READY = 1'b1;
    BYTE_READ = 8'hF5;
    MOVE_VALID = 1'b1;
    @(negedge CLK);
    BYTE_READY = 1'b0;
    MOVE_VALID = 1'b0;
    wait_tx(1);
    repeat (12) @(negedge CLK);
    chk("tie_ack", tx_q[0], 8'hFA);
    chk("tie_len", tx_q.size(), 1);
    chk("tie_no_accept", acc_cnt - acc0, 0);
    chk("tie_streaming", STREAMING, 0);

    chk("single_send_pulse", extra_send, 0);
    chk("read_enable_during_tx", re_bad, 0);

    // Reset while an ack is in flight clears everything
    clr();
    host_send(8'hF4, 2'b00);
    @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    chk("mid_rst_read_enable", READ_ENABLE, 0);
    chk("mid_rst_byte", BYTE_TO_SEND, 8'h00);
    chk("mid_rst_streaming", STREAMING, 0);
    chk("mid_rst_intelli", INTELLIMOUSE, 0);
    chk("mid_rst_rate", SAMPLE_RATE, 8'h64);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
